// File: rtl/rs_muldiv_pkg.sv
// Shared types and constants for the mul/div reservation station.
// Optional age-ordered issue is enabled with RS_MULDIV_AGE_PRIORITY_EN.
package rs_muldiv_pkg;

  localparam int unsigned LABEL_W = 2;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MUL = 3'b010,
    OP_DIV = 3'b011
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic               busy;
    logic               issued;
    logic               rdy_j;
    logic               rdy_k;
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  vj;
    logic [DATA_W-1:0]  vk;
    logic [LABEL_W-1:0] qj;
    logic [LABEL_W-1:0] qk;
  } entry_t;

  // Index width that stays legal for a single-entry station.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_muldiv_select.sv
// Combinational ready-entry picker: lowest index by default, oldest entry
// when RS_MULDIV_AGE_PRIORITY_EN is defined.
module rs_muldiv_select
  import rs_muldiv_pkg::*;
#(
  parameter int unsigned ENTRIES = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [ENTRIES-1:0]            ready_i,
`ifdef RS_MULDIV_AGE_PRIORITY_EN
  input  logic [ENTRIES-1:0][IDX_W-1:0] age_i,
`endif
  output logic                          sel_valid_c,
  output logic [IDX_W-1:0]              sel_idx_c
);

`ifdef RS_MULDIV_AGE_PRIORITY_EN
  logic [IDX_W-1:0] best_age;

  // Strict compare keeps the lower index on equal ages.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_idx_c   = '0;
    best_age    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_i[i] && (!sel_valid_c || (age_i[i] > best_age))) begin
        sel_valid_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
        best_age    = age_i[i];
      end
    end
  end
`else
  always_comb begin
    sel_valid_c = 1'b0;
    sel_idx_c   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_i[i] && !sel_valid_c) begin
        sel_valid_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/rs_muldiv.sv
// Reservation station for the mul/div FU: holds dispatched ops, snoops the CDB
// and issues one ready op at a time. RS_MULDIV_AGE_PRIORITY_EN selects oldest-first issue.
module rs_muldiv
  import rs_muldiv_pkg::*;
#(
  parameter int unsigned        ENTRIES    = 2,
  parameter logic [LABEL_W-1:0] LABEL_BASE = 2'd0
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Dispatch,
  input  logic [OP_W-1:0]    DispOp,
  input  logic [DATA_W-1:0]  DispVj,
  input  logic [DATA_W-1:0]  DispVk,
  input  logic               DispRdyJ,
  input  logic               DispRdyK,
  input  logic [LABEL_W-1:0] DispQj,
  input  logic [LABEL_W-1:0] DispQk,
  output logic [LABEL_W-1:0] DispLabel,
  output logic               Full,
  input  logic               CDBValid,
  input  logic [LABEL_W-1:0] CDBLabel,
  input  logic [DATA_W-1:0]  CDBData,
  output logic               FUEn,
  output logic [DATA_W-1:0]  FURx,
  output logic [DATA_W-1:0]  FURy,
  output logic [OP_W-1:0]    FUOp,
  output logic [LABEL_W-1:0] FULabel,
  input  logic               FUDone,
  input  logic [LABEL_W-1:0] FULabelIn
);

  localparam int unsigned IDX_W = idx_width(ENTRIES);

  entry_t [ENTRIES-1:0] entry_q, entry_d;
  state_e               state_q, state_d;
  logic                 fu_en_q, fu_en_d;
  logic [DATA_W-1:0]    fu_rx_q, fu_rx_d, fu_ry_q, fu_ry_d;
  logic [OP_W-1:0]      fu_op_q, fu_op_d;
  logic [LABEL_W-1:0]   fu_label_q, fu_label_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;

  logic [ENTRIES-1:0]   busy_c, ready_c, avail_c, free_vec_c;
  logic                 full_c, free_c, alloc_c, alloc_found_c, issue_c;
  logic [IDX_W-1:0]     alloc_idx_c;
  logic                 sel_valid_c;
  logic [IDX_W-1:0]     sel_idx_c;
  entry_t               sel_entry_c;
  logic                 disp_rdy_j_c, disp_rdy_k_c;
  logic [DATA_W-1:0]    disp_vj_c, disp_vk_c;

  // Status vectors, free/alloc decisions and dispatch-side CDB bypass.
  always_comb begin
    free_c        = (state_q == BUSY) && FUDone && (FULabelIn == fu_label_q);
    alloc_found_c = 1'b0;
    alloc_idx_c   = '0;
    sel_entry_c   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_c[i]     = entry_q[i].busy;
      ready_c[i]    = entry_q[i].busy && entry_q[i].rdy_j && entry_q[i].rdy_k
                      && !entry_q[i].issued;
      free_vec_c[i] = free_c && (cur_idx_q == IDX_W'(i));
      avail_c[i]    = !entry_q[i].busy || free_vec_c[i];
      if (avail_c[i] && !alloc_found_c) begin
        alloc_found_c = 1'b1;
        alloc_idx_c   = IDX_W'(i);
      end
      if (sel_idx_c == IDX_W'(i)) sel_entry_c = entry_q[i];
    end
    full_c       = &busy_c;
    alloc_c      = Dispatch && !full_c && alloc_found_c;
    issue_c      = (state_q == IDLE) && sel_valid_c;
    disp_rdy_j_c = DispRdyJ || (CDBValid && (DispQj == CDBLabel));
    disp_rdy_k_c = DispRdyK || (CDBValid && (DispQk == CDBLabel));
    disp_vj_c    = DispRdyJ ? DispVj : CDBData;
    disp_vk_c    = DispRdyK ? DispVk : CDBData;
  end

  assign Full      = full_c;
  assign DispLabel = LABEL_W'(32'(LABEL_BASE) + 32'(alloc_idx_c));

`ifdef RS_MULDIV_AGE_PRIORITY_EN
  logic [ENTRIES-1:0][IDX_W-1:0] age_q, age_d;
  logic [IDX_W-1:0]              freed_age_c;

  // Busy entries hold distinct ages 0..n-1; larger means allocated earlier.
  always_comb begin
    freed_age_c = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (cur_idx_q == IDX_W'(i)) freed_age_c = age_q[i];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (busy_c[i] && !free_vec_c[i]) begin
        if (free_c && (age_q[i] > freed_age_c)) age_d[i] = age_d[i] - IDX_W'(1);
        if (alloc_c) age_d[i] = age_d[i] + IDX_W'(1);
      end
      if (alloc_c && (alloc_idx_c == IDX_W'(i))) age_d[i] = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) age_q <= '0;
    else         age_q <= age_d;
  end
`endif

  rs_muldiv_select #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_select (
    .ready_i     (ready_c),
`ifdef RS_MULDIV_AGE_PRIORITY_EN
    .age_i       (age_q),
`endif
    .sel_valid_c (sel_valid_c),
    .sel_idx_c   (sel_idx_c)
  );

  // Per-entry update: snoop, free, issue mark; allocation overrides all.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].busy && CDBValid) begin
        if (!entry_q[i].rdy_j && (entry_q[i].qj == CDBLabel)) begin
          entry_d[i].vj    = CDBData;
          entry_d[i].rdy_j = 1'b1;
        end
        if (!entry_q[i].rdy_k && (entry_q[i].qk == CDBLabel)) begin
          entry_d[i].vk    = CDBData;
          entry_d[i].rdy_k = 1'b1;
        end
      end
      if (free_vec_c[i]) begin
        entry_d[i].busy   = 1'b0;
        entry_d[i].issued = 1'b0;
      end
      if (issue_c && (sel_idx_c == IDX_W'(i))) entry_d[i].issued = 1'b1;
      if (alloc_c && (alloc_idx_c == IDX_W'(i))) begin
        entry_d[i] = '{busy: 1'b1, issued: 1'b0, rdy_j: disp_rdy_j_c,
                       rdy_k: disp_rdy_k_c, op: DispOp, vj: disp_vj_c,
                       vk: disp_vk_c, qj: DispQj, qk: DispQk};
      end
    end
  end

  // Issue FSM: FU outputs only change on issue; FUEn drops on matching Done.
  always_comb begin
    state_d    = state_q;
    fu_en_d    = fu_en_q;
    fu_rx_d    = fu_rx_q;
    fu_ry_d    = fu_ry_q;
    fu_op_d    = fu_op_q;
    fu_label_d = fu_label_q;
    cur_idx_d  = cur_idx_q;
    case (state_q)
      IDLE: begin
        if (issue_c) begin
          state_d    = BUSY;
          fu_en_d    = 1'b1;
          fu_rx_d    = sel_entry_c.vj;
          fu_ry_d    = sel_entry_c.vk;
          fu_op_d    = sel_entry_c.op;
          fu_label_d = LABEL_W'(32'(LABEL_BASE) + 32'(sel_idx_c));
          cur_idx_d  = sel_idx_c;
        end
      end
      BUSY: begin
        if (free_c) begin
          state_d = IDLE;
          fu_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      fu_en_q    <= 1'b0;
      fu_rx_q    <= '0;
      fu_ry_q    <= '0;
      fu_op_q    <= '0;
      fu_label_q <= '0;
      cur_idx_q  <= '0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      fu_en_q    <= fu_en_d;
      fu_rx_q    <= fu_rx_d;
      fu_ry_q    <= fu_ry_d;
      fu_op_q    <= fu_op_d;
      fu_label_q <= fu_label_d;
      cur_idx_q  <= cur_idx_d;
      entry_q    <= entry_d;
    end
  end

  assign FUEn    = fu_en_q;
  assign FURx    = fu_rx_q;
  assign FURy    = fu_ry_q;
  assign FUOp    = fu_op_q;
  assign FULabel = fu_label_q;

endmodule

// File: doc/rs_muldiv.md
Name: rs_muldiv

Overview:
- Reservation station feeding the multiply/divide functional unit; it is the issuing side of the FU's en/Rx/Ry/Op/Label -> out/Done/LabelOut interface.
- Accepts dispatched mul/div instructions and holds them until both operands are valid.
- Snoops the common data bus (CDB) for pending operand tags.
- Issues one ready entry at a time to the FU and frees the entry when the FU signals Done.

Parameters:
- ENTRIES, 2, number of station entries (1..4; must fit the 2-bit label space).
- LABEL_BASE, 2'd0, label of entry 0; entry i carries label LABEL_BASE+i, modulo 4.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Resetn  in  1  synchronous, active-low reset.
- Dispatch  in  1  dispatch request this cycle.
- DispOp  in  3  opcode: 3'b010 = mul, 3'b011 = div.
- DispVj, DispVk  in  12  operand values.
- DispRdyJ, DispRdyK  in  1  operand value valid.
- DispQj, DispQk  in  2  producer label when the operand is not ready.
- DispLabel  out  2  label of the entry allocated this cycle.
- Full  out  1  no free entry.
- CDBValid  in  1  CDB broadcast valid.
- CDBLabel  in  2  CDB producer label.
- CDBData  in  12  CDB value.
- FUEn  out  1  FU enable.
- FURx, FURy  out  12  operands to the FU.
- FUOp  out  3  opcode to the FU.
- FULabel  out  2  label to the FU.
- FUDone  in  1  FU result complete.
- FULabelIn  in  2  label returned by the FU.

Behaviour:
- Reset (Resetn=0 at posedge): all entries not busy, issue FSM IDLE. FUEn=0, FURx=FURy=0, FUOp=0, FULabel=0, Full=0. Reset mid-operation abandons the in-flight op; a later Done is ignored because no entry matches.
- Entry contents: busy, op, Vj, Vk, rdyJ, rdyK, Qj, Qk, issued.
- Allocation: on Dispatch && !Full, the lowest-index free entry is written. DispLabel reflects that entry combinationally. Dispatch while Full is dropped silently.
- Full is combinational: all entries busy.
- CDB snoop: every busy entry with !rdyX && Qx==CDBLabel && CDBValid captures CDBData into Vx and sets rdyX.
- Same-cycle bypass: a dispatched operand whose Q matches the current CDB broadcast is written already ready, with the CDB value.
- Ready entry: busy && rdyJ && rdyK && !issued.
- Issue FSM, IDLE:
  - If a ready entry exists, select one, latch its Vj/Vk/op/label into FURx/FURy/FUOp/FULabel, set FUEn=1, mark the entry issued, go to BUSY.
  - An entry that became ready at posedge N can issue no earlier than posedge N+1.
- Issue FSM, BUSY:
  - FU outputs are held stable.
  - At a posedge with FUDone && FULabelIn==FULabel: clear the entry's busy, set FUEn=0, go to IDLE.
  - FUEn is therefore low for at least one full cycle between ops, so the FU's internal counter restarts.
  - A freed entry may be re-allocated by a Dispatch in the same cycle.
- FU contract: the FU asserts Done on the second negedge after FUEn rises. Issue-to-free is 2 posedges; back-to-back issue period is 3 cycles.
- Simultaneous events: dispatch, CDB capture and free may all occur in one cycle. The CDB update applies to entries that are already busy and, through the bypass, to the newly dispatched entry.
- Arithmetic: none in this block; divide-by-zero is passed to the FU unchecked. The station's own result broadcast is not snooped by itself (the CDB arbiter handles it).

Optional Feature:
- Macro RS_MULDIV_AGE_PRIORITY_EN.
- Defined: each entry has an age counter (width clog2(ENTRIES)); selection picks the oldest ready entry.
- Not defined: selection picks the lowest-index ready entry (fixed priority, no age state).

Decomposition:
- Shared package: opcode constants (OP_MUL=3'b010, OP_DIV=3'b011), LABEL_W=2, DATA_W=12, FSM state encoding (IDLE/BUSY).
- One sub-module: rs_muldiv_select, the combinational ready-entry picker. It takes the ready vector (plus ages when the macro is enabled) and returns a valid flag and an index.

Test Plan:
- Dispatch mul, Vj=3, Vk=5, both ready -> FUEn=1 next posedge with FURx=3, FURy=5, FUOp=010, FULabel=0. Model FU returns Done and out=15 after 2 cycles -> entry freed, FUEn=0 for one cycle.
- Dispatch div, Qj=3, rdyK=1, Vk=4 -> no issue. CDB label 3, data 20 -> issue next cycle with FURx=20, FURy=4, FUOp=011.
- Same-cycle bypass: Dispatch with Qj=2 while CDB broadcasts label 2, data 7 -> entry ready immediately; FURx=7.
- Fill both entries -> Full=1. A third dispatch is dropped. Entries issue back-to-back with a 3-cycle period; Full clears as entry 0 is freed.
- Resetn=0 while in BUSY -> FUEn=0, Full=0 next posedge. A following FUDone with a stale label is ignored.
- With RS_MULDIV_AGE_PRIORITY_EN: entry 1 becomes ready before entry 0 -> entry 1 is issued first. Without the macro -> entry 0 is issued first when both are ready in the same cycle.
